// File: rtl/freq_key_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : freq_key_ctrl
//  Purpose  : Debounces two active-low push buttons (up / down) and maintains
//             the 8-bit frequency-control word for the waveform generators.
//             Single step on press, auto-repeat on long hold, saturation at
//             FREQ_MIN / FREQ_MAX, and an up+down chord that restores
//             FREQ_INIT.
//  Ports    : clk          - system clock
//             rst_n        - asynchronous active-low reset
//             i_key_up     - raw up button, active low, asynchronous
//             i_key_dn     - raw down button, active low, asynchronous
//             o_freq_ctrl  - current frequency-control word
//             o_freq_chg   - one-cycle pulse when o_freq_ctrl takes a new value
//             o_at_limit   - high while o_freq_ctrl is FREQ_MIN or FREQ_MAX
//  Options  : FREQ_WRAP_EN - when defined, steps wrap around at the limits
//                            instead of saturating.
//  Revision : 1.0 - initial release
// ============================================================================
module freq_key_ctrl #(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned LONG_CYC     = 50_000_000,
  parameter int unsigned REPEAT_CYC   = 10_000_000,
  parameter logic [7:0]  FREQ_MIN     = 8'd1,
  parameter logic [7:0]  FREQ_MAX     = 8'd16,
  parameter logic [7:0]  FREQ_INIT    = 8'd2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_key_up,
  input  logic       i_key_dn,
  output logic [7:0] o_freq_ctrl,
  output logic       o_freq_chg,
  output logic       o_at_limit
);

  localparam int unsigned DB_W     = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned HOLD_MAX = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
  localparam int unsigned HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

  localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST   = HOLD_W'(LONG_CYC - 1);
  localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HELD   = 2'd1,
    S_REPEAT = 2'd2,
    S_LOCK   = 2'd3
  } state_t;

  // Bit 0 = up key, bit 1 = down key
  logic [1:0] w_raw;
  logic [1:0] w_pressed;
  logic [1:0] w_locked;
  logic [1:0] w_step;
  logic       w_chord;

  assign w_raw = {i_key_dn, i_key_up};

  // A chord is only recognised while neither key is still locked from the
  // previous chord, so holding one key through a release of the other cannot
  // retrigger it.
  assign w_chord = (&w_pressed) & ~(|w_locked);

  for (genvar k = 0; k < 2; k++) begin : g_key
    logic              r_sync1;
    logic              r_sync2;
    logic              r_level;     // debounced level, 1 = released
    logic [DB_W-1:0]   r_db_cnt;
    state_t            r_state;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_step;

    // Two-flop synchronizer followed by the debounce counter. The counter
    // only runs while the synced level disagrees with the accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sync1  <= 1'b1;
        r_sync2  <= 1'b1;
        r_level  <= 1'b1;
        r_db_cnt <= '0;
      end else begin
        r_sync1 <= w_raw[k];
        r_sync2 <= r_sync1;
        if (r_sync2 == r_level) begin
          r_db_cnt <= '0;
        end else if (r_db_cnt == DB_LAST) begin
          r_level  <= r_sync2;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
      end
    end

    // Press / hold / repeat state machine. r_step is a one-cycle event that
    // the frequency register consumes on the following edge.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state    <= S_IDLE;
        r_hold_cnt <= '0;
        r_step     <= 1'b0;
      end else begin
        r_step <= 1'b0;
        if (w_chord) begin
          r_state    <= S_LOCK;
          r_hold_cnt <= '0;
        end else begin
          case (r_state)
            S_IDLE: begin
              if (!r_level) begin
                r_state    <= S_HELD;
                r_step     <= 1'b1;
                r_hold_cnt <= '0;
              end
            end
            S_HELD: begin
              if (r_level) begin
                r_state    <= S_IDLE;
                r_hold_cnt <= '0;
              end else if (r_hold_cnt == LONG_LAST) begin
                r_state    <= S_REPEAT;
                r_step     <= 1'b1;
                r_hold_cnt <= '0;
              end else begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
              end
            end
            S_REPEAT: begin
              if (r_level) begin
                r_state    <= S_IDLE;
                r_hold_cnt <= '0;
              end else if (r_hold_cnt == REPEAT_LAST) begin
                r_step     <= 1'b1;
                r_hold_cnt <= '0;
              end else begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
              end
            end
            S_LOCK: begin
              if (r_level) begin
                r_state <= S_IDLE;
              end
            end
            default: begin
              r_state    <= S_IDLE;
              r_hold_cnt <= '0;
            end
          endcase
        end
      end
    end

    assign w_pressed[k] = ~r_level;
    assign w_locked[k]  = (r_state == S_LOCK);
    assign w_step[k]    = r_step;
  end

  // --------------------------------------------------------------------------
  // Frequency register
  // --------------------------------------------------------------------------
  logic [7:0] r_freq;
  logic       r_chg;
  logic       r_lim;
  logic [7:0] w_up_val;
  logic [7:0] w_dn_val;
  logic [7:0] w_next;

  always_comb begin
`ifdef FREQ_WRAP_EN
    w_up_val = (r_freq >= FREQ_MAX) ? FREQ_MIN : r_freq + 8'd1;
    w_dn_val = (r_freq <= FREQ_MIN) ? FREQ_MAX : r_freq - 8'd1;
`else
    w_up_val = (r_freq >= FREQ_MAX) ? FREQ_MAX : r_freq + 8'd1;
    w_dn_val = (r_freq <= FREQ_MIN) ? FREQ_MIN : r_freq - 8'd1;
`endif
  end

  // The chord wins over a step event pending in the same cycle. Simultaneous
  // up and down events cancel out.
  always_comb begin
    w_next = r_freq;
    if (w_chord) begin
      w_next = FREQ_INIT;
    end else if (w_step == 2'b01) begin
      w_next = w_up_val;
    end else if (w_step == 2'b10) begin
      w_next = w_dn_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_freq <= FREQ_INIT;
      r_chg  <= 1'b0;
      r_lim  <= (FREQ_INIT == FREQ_MIN) || (FREQ_INIT == FREQ_MAX);
    end else begin
      r_freq <= w_next;
      r_chg  <= (w_next != r_freq);
      r_lim  <= (w_next == FREQ_MIN) || (w_next == FREQ_MAX);
    end
  end

  assign o_freq_ctrl = r_freq;
  assign o_freq_chg  = r_chg;
  assign o_at_limit  = r_lim;

endmodule
`default_nettype wire

// File: tb/tb_freq_key_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_freq_key_ctrl
//  Purpose  : Self-checking bench for freq_key_ctrl with short timing
//             parameters (DEBOUNCE=8, LONG=40, REPEAT=10, MIN=1, MAX=16,
//             INIT=2). Expected values come from a vector table, directed
//             corner sequences and a hold-duration based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_freq_key_ctrl;

  localparam int D     = 8;
  localparam int LC    = 40;
  localparam int RC    = 10;
  localparam int FMIN  = 1;
  localparam int FMAX  = 16;
  localparam int FINIT = 2;
  localparam int SETTLE = D + 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_up = 1'b1;
  logic       key_dn = 1'b1;
  logic [7:0] freq;
  logic       chg;
  logic       lim;

  freq_key_ctrl #(
    .DEBOUNCE_CYC (D),
    .LONG_CYC     (LC),
    .REPEAT_CYC   (RC),
    .FREQ_MIN     (8'(FMIN)),
    .FREQ_MAX     (8'(FMAX)),
    .FREQ_INIT    (8'(FINIT))
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_key_up    (key_up),
    .i_key_dn    (key_dn),
    .o_freq_ctrl (freq),
    .o_freq_chg  (chg),
    .o_at_limit  (lim)
  );

  always #5 clk = ~clk;

  int n_chk     = 0;
  int n_fail    = 0;
  int chg_total = 0;
  int model     = FINIT;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Cycle-by-cycle invariants: a change pulse accompanies every new value and
  // only then; at_limit tracks the current value.
  logic [7:0] prev_freq;
  bit         prev_ok = 1'b0;
  always @(negedge clk) begin
    if (chg === 1'b1) chg_total++;
    if (rst_n && prev_ok) begin
      check("chg_tracks_change", 32'(chg), 32'(freq != prev_freq));
      check("at_limit_tracks_value", 32'(lim), 32'((freq == FMIN) || (freq == FMAX)));
    end
    prev_freq = freq;
    prev_ok   = rst_n;
  end

  // Number of step events produced by a clean hold of n cycles: one on the
  // press, one after LC cycles, then one every RC cycles while still held.
  function automatic int n_steps(input int n);
    if (n < D) return 0;
    if (n - 1 < LC) return 1;
    return 2 + (n - 1 - LC) / RC;
  endfunction

  function automatic int step_val(input int f, input bit up);
    if (up) return (f >= FMAX) ? FMAX : f + 1;
    return (f <= FMIN) ? FMIN : f - 1;
  endfunction

  function automatic int is_lim(input int f);
    return ((f == FMIN) || (f == FMAX)) ? 1 : 0;
  endfunction

  // Hold one key for n cycles, release, let it settle. Updates the model and
  // returns the expected and observed number of change pulses.
  task automatic press(input bit up, input int n, output int exp_chg, output int got_chg);
    int c0;
    int nv;
    exp_chg = 0;
    for (int i = 0; i < n_steps(n); i++) begin
      nv = step_val(model, up);
      if (nv != model) exp_chg++;
      model = nv;
    end
    c0 = chg_total;
    @(negedge clk);
    if (up) key_up = 1'b0; else key_dn = 1'b0;
    repeat (n) @(negedge clk);
    key_up = 1'b1;
    key_dn = 1'b1;
    repeat (SETTLE) @(negedge clk);
    got_chg = chg_total - c0;
  endtask

  typedef struct {
    bit up;
    int hold;
    int exp_freq;
    int exp_chg;
    int exp_lim;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int e, g, c0, waited;
    bit found;

    tbl[0]  = '{1'b1, 20,  3,  1, 0};
    tbl[1]  = '{1'b0, 20,  2,  1, 0};
    tbl[2]  = '{1'b1, 65,  6,  4, 0};
    tbl[3]  = '{1'b0, 65,  2,  4, 0};
    tbl[4]  = '{1'b0, 20,  1,  1, 1};
    tbl[5]  = '{1'b0, 65,  1,  0, 1};
    tbl[6]  = '{1'b1, 7,   1,  0, 1};
    tbl[7]  = '{1'b1, 8,   2,  1, 0};
    tbl[8]  = '{1'b1, 175, 16, 14, 1};
    tbl[9]  = '{1'b1, 20,  16, 0, 1};
    tbl[10] = '{1'b0, 20,  15, 1, 0};
    tbl[11] = '{1'b0, 41,  13, 2, 0};
    tbl[12] = '{1'b0, 40,  12, 1, 0};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_freq", 32'(freq), 32'(FINIT));
    check("reset_chg", 32'(chg), 32'd0);
    check("reset_lim", 32'(lim), 32'd0);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    model = FINIT;

    // Vector table
    foreach (tbl[i]) begin
      press(tbl[i].up, tbl[i].hold, e, g);
      check($sformatf("tbl%0d_freq", i), 32'(freq), 32'(tbl[i].exp_freq));
      check($sformatf("tbl%0d_chg_count", i), 32'(g), 32'(tbl[i].exp_chg));
      check($sformatf("tbl%0d_lim", i), 32'(lim), 32'(tbl[i].exp_lim));
    end

    // Bouncing down key: 5-cycle lows never last long enough to be accepted
    c0 = chg_total;
    for (int p = 0; p < 8; p++) begin
      key_dn = 1'b0;
      repeat (5) @(negedge clk);
      key_dn = 1'b1;
      repeat (3) @(negedge clk);
    end
    repeat (SETTLE) @(negedge clk);
    check("bounce_chg_count", 32'(chg_total - c0), 32'd0);
    check("bounce_freq", 32'(freq), 32'(model));

    // Chord from 9: up pressed one cycle before down
    for (int i = 0; i < 3; i++) press(1'b0, 20, e, g);
    check("chord_setup_freq", 32'(freq), 32'd9);
    c0 = chg_total;
    key_up = 1'b0;
    @(negedge clk);
    key_dn = 1'b0;
    repeat (30) @(negedge clk);
    key_dn = 1'b1;
    repeat (100) @(negedge clk);
    check("chord_chg_count", 32'(chg_total - c0), 32'd1);
    check("chord_freq", 32'(freq), 32'(FINIT));
    c0 = chg_total;
    key_up = 1'b1;
    repeat (SETTLE) @(negedge clk);
    check("chord_release_chg_count", 32'(chg_total - c0), 32'd0);
    model = FINIT;
    press(1'b1, 20, e, g);
    check("after_chord_repress_freq", 32'(freq), 32'd3);
    check("after_chord_repress_chg", 32'(g), 32'd1);

    // Reset during auto-repeat at 10 with the key still held afterwards
    key_up = 1'b0;
    found  = 1'b0;
    waited = 0;
    while (!found && waited < 300) begin
      @(negedge clk);
      waited++;
      if (freq == 8'd10) found = 1'b1;
    end
    check("repeat_reaches_10", 32'(found), 32'd1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_reset_freq", 32'(freq), 32'(FINIT));
    check("midrun_reset_chg", 32'(chg), 32'd0);
    repeat (3) @(negedge clk);
    c0 = chg_total;
    #2 rst_n = 1'b1;
    repeat (30) @(negedge clk);
    key_up = 1'b1;
    repeat (SETTLE) @(negedge clk);
    check("post_reset_chg_count", 32'(chg_total - c0), 32'd1);
    check("post_reset_freq", 32'(freq), 32'd3);
    model = 3;

    // Randomized holds and chords against the hold-duration model
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        int h;
        int exp_c;
        h = $urandom_range(10, 50);
        exp_c = (model != FINIT) ? 1 : 0;
        c0 = chg_total;
        @(negedge clk);
        key_up = 1'b0;
        key_dn = 1'b0;
        repeat (h) @(negedge clk);
        key_up = 1'b1;
        key_dn = 1'b1;
        repeat (SETTLE) @(negedge clk);
        model = FINIT;
        check($sformatf("rnd%0d_chord_chg", it), 32'(chg_total - c0), 32'(exp_c));
      end else begin
        bit up;
        int h;
        up = 1'($urandom_range(0, 1));
        h  = $urandom_range(1, 120);
        press(up, h, e, g);
        check($sformatf("rnd%0d_chg_up%0d_h%0d", it, up, h), 32'(g), 32'(e));
      end
      check($sformatf("rnd%0d_freq", it), 32'(freq), 32'(model));
      check($sformatf("rnd%0d_lim", it), 32'(lim), 32'(is_lim(model)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
